mult_share_arbiter: RTL and testbench

//  Shares one pipelined 4x4 Wallace multiplier between NUM_REQ requesters.

---
 rtl/mult_share_arbiter.sv | 107 ++++++++++
 tb/tb_mult_share_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin front end that shares one pipelined 4x4 multiplier between NUM_REQ clients.
// Optional per-requester grant counters are compiled in when MULT_ARB_STATS_EN is defined.
module mult_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [4*NUM_REQ-1:0] req_a,
    input  logic [4*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [3:0]           mul_a,
    output logic [3:0]           mul_b,
    input  logic [7:0]           mul_prod,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp_prod,
    output logic                 busy
`ifdef MULT_ARB_STATS_EN
    ,
    input  logic [ID_W-1:0]      stat_sel,
    output logic [15:0]          stat_cnt
`endif
);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] gnt_idx;
    logic            found;
    logic            transfer;
    logic [ID_W:0]   cand;

    logic [MUL_LAT:0] tag_v;
    logic [ID_W-1:0]  tag_id [MUL_LAT+1];

    // Search from ptr upward, wrapping at NUM_REQ; first valid requester wins.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!found && req_valid[cand[ID_W-1:0]]) begin
                found   = 1'b1;
                gnt_idx = cand[ID_W-1:0];
            end
        end
    end

    assign transfer  = found && enable && !rst;
    assign req_ready = transfer ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign busy      = (|tag_v) | rsp_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            tag_v     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_prod  <= '0;
            for (int unsigned k = 0; k <= MUL_LAT; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            if (transfer) begin
                mul_a <= req_a[4*gnt_idx +: 4];
                mul_b <= req_b[4*gnt_idx +: 4];
                ptr   <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
            end
            // Tag pipe never stalls; bubbles carry a don't-care id.
            tag_v     <= {tag_v[MUL_LAT-1:0], transfer};
            tag_id[0] <= gnt_idx;
            for (int unsigned k = 1; k <= MUL_LAT; k++) begin
                tag_id[k] <= tag_id[k-1];
            end
            rsp_valid <= tag_v[MUL_LAT];
            if (tag_v[MUL_LAT]) begin
                rsp_id   <= tag_id[MUL_LAT];
                rsp_prod <= mul_prod;
            end
        end
    end

`ifdef MULT_ARB_STATS_EN
    logic [15:0] grant_cnt [NUM_REQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                grant_cnt[k] <= '0;
            end
        end else if (transfer && grant_cnt[gnt_idx] != '1) begin
            grant_cnt[gnt_idx] <= grant_cnt[gnt_idx] + 16'd1;
        end
    end

    assign stat_cnt = grant_cnt[stat_sel];
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized bench for mult_share_arbiter against a queue-based transaction model.
// Define MULT_ARB_STATS_EN to also check the grant counters.
module tb_mult_share_arbiter;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [3:0]  req_valid;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_ready;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic [7:0]  mul_prod;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_prod;
    logic        busy;
`ifdef MULT_ARB_STATS_EN
    logic [1:0]  stat_sel;
    logic [15:0] stat_cnt;
`endif

    mult_share_arbiter #(.NUM_REQ(4), .ID_W(2), .MUL_LAT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_prod  (mul_prod),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod),
        .busy      (busy)
`ifdef MULT_ARB_STATS_EN
        ,
        .stat_sel  (stat_sel),
        .stat_cnt  (stat_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Two-cycle multiplier stand-in for the Wallace block.
    logic [7:0] mul_p1;
    always @(posedge clk) begin
        mul_p1   <= 8'(mul_a) * 8'(mul_b);
        mul_prod <= mul_p1;
    end

    typedef struct {
        int id;
        int prod;
        int due;
    } op_t;

    op_t q[$];
    int  m_ptr;
    int  m_cnt [4];
    int  cyc;
    int  checks;
    int  errors;
    bit  mon_on;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    // Reference: pending ops are listed with the cycle their response is due.
    always @(negedge clk) begin
        if (mon_on) begin
            int g;
            int idx;
            int exp_ready;
            g = -1;
            if (enable && !rst) begin
                for (int k = 0; k < 4; k++) begin
                    idx = (m_ptr + k) % 4;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            exp_ready = (g >= 0) ? (1 << g) : 0;
            check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
            check_eq("busy", 32'(busy), 32'(q.size() > 0));
            if (q.size() > 0 && q[0].due == cyc) begin
                check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
                check_eq("rsp_id", 32'(rsp_id), 32'(q[0].id));
                check_eq("rsp_prod", 32'(rsp_prod), 32'(q[0].prod));
                void'(q.pop_front());
            end else begin
                check_eq("rsp_idle", 32'(rsp_valid), 32'd0);
            end
`ifdef MULT_ARB_STATS_EN
            check_eq("stat_cnt", 32'(stat_cnt), 32'(m_cnt[stat_sel]));
`endif
            if (g >= 0) begin
                q.push_back('{id: g,
                              prod: int'(req_a[4*g +: 4]) * int'(req_b[4*g +: 4]),
                              due: cyc + 4});
                m_ptr = (g + 1) % 4;
                if (m_cnt[g] < 65535) m_cnt[g]++;
            end
            if (rst) begin
                q.delete();
                m_ptr = 0;
                for (int k = 0; k < 4; k++) m_cnt[k] = 0;
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
`ifdef MULT_ARB_STATS_EN
        stat_sel = 2'($urandom_range(0, 3));
`endif
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] a, input logic [3:0] b);
        req_valid[i]     = v;
        req_a[4*i +: 4] = a;
        req_b[4*i +: 4] = b;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        m_ptr     = 0;
        mon_on    = 1'b0;
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
        rst       = 1'b1;
        enable    = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
`ifdef MULT_ARB_STATS_EN
        stat_sel  = '0;
`endif
        step();
        step();
        rst = 1'b0;
        check_eq("rst_mul_a", 32'(mul_a), 32'd0);
        check_eq("rst_mul_b", 32'(mul_b), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_id", 32'(rsp_id), 32'd0);
        check_eq("rst_rsp_prod", 32'(rsp_prod), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        mon_on = 1'b1;
        enable = 1'b1;

        // Single op from requester 0: 3*5.
        set_req(0, 1'b1, 4'd3, 4'd5);
        step();
        req_valid = '0;
        repeat (6) step();

        // All four requesters, a=i+1, b=15.
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 4'(i + 1), 4'd15);
        repeat (8) step();
        req_valid = '0;
        repeat (6) step();

        // Requesters 1 and 3 alternate: 225 and 0.
        set_req(1, 1'b1, 4'd15, 4'd15);
        set_req(3, 1'b1, 4'd0, 4'd9);
        repeat (8) step();
        req_valid = '0;
        repeat (6) step();

        // Enable drops after two transfers; in-flight ops must still drain.
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 4'(i + 7), 4'(i + 2));
        repeat (2) step();
        enable = 1'b0;
        repeat (8) step();
        enable = 1'b1;
        req_valid = '0;
        step();

        // Reset with three ops in flight, then only the upper two request.
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 4'(i + 4), 4'(i + 9));
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 4'b1100;
        repeat (4) step();
        req_valid = '0;
        repeat (6) step();

        // Random traffic with occasional enable drops and resets.
        for (int n = 0; n < 1500; n++) begin
            req_valid = 4'($urandom);
            req_a     = 16'($urandom);
            req_b     = 16'($urandom);
            enable    = ($urandom_range(0, 9) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            step();
        end
        rst       = 1'b0;
        req_valid = '0;
        repeat (8) step();
        check_eq("drain_empty", 32'(q.size()), 32'd0);
        check_eq("drain_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
